// File: rtl/led_pkg.sv
// Shared definitions for the LED/A1 pattern arbiter: FSM state encoding,
// default geometry and the idle heartbeat decode.
package led_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_PLAY = 2'd2,
      ST_GAP  = 2'd3
   } led_state_t;

   localparam int LED_PAT_W            = 32;
   localparam int LED_REP_W            = 4;
   localparam int LED_STEP_DIV_DEFAULT = 2097152;
   localparam int LED_HB_W             = 24;

   // Heartbeat is lit for the first eighth of each 2^24-cycle period.
   function automatic logic led_hb_on(input logic [LED_HB_W-1:0] cnt);
      return (cnt[LED_HB_W-1 -: 3] == 3'b000);
   endfunction

endpackage

// File: rtl/led_pattern_arbiter_if.sv
// Request/handshake bundle between the status sources (master) and the
// LED pattern arbiter (slave).
interface led_pattern_arbiter_if
   import led_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int PAT_W   = LED_PAT_W,
   parameter int REP_W   = LED_REP_W
) ();
   localparam int GID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ*PAT_W-1:0] req_pattern;
   logic [NUM_REQ*REP_W-1:0] req_repeat;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ-1:0]       done;
   logic                     busy;
   logic [GID_W-1:0]         grant_id;

   modport master (
      output req_valid, req_pattern, req_repeat,
      input  req_ready, done, busy, grant_id
   );

   modport slave (
      input  req_valid, req_pattern, req_repeat,
      output req_ready, done, busy, grant_id
   );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester found scanning upward from
// last+1 with wrap-around. Usable by any shared-pin controller.
module rr_arbiter #(
   parameter  int N = 4,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] last,
   output logic         any,
   output logic [W-1:0] gnt_id
);

   // Scan N candidates starting after the previous winner.
   always_comb begin : scan
      logic [W-1:0] cand;
      any    = 1'b0;
      gnt_id = {W{1'b0}};
      cand   = {W{1'b0}};
      for (int i = 1; i <= N; i++) begin
         cand   = W'((int'(last) + i) % N);
         gnt_id = (req[cand] && !any) ? cand : gnt_id;
         any    = any | req[cand];
      end
   end

endmodule

// File: rtl/led_pattern_arbiter.sv
// Round-robin owner of the user LED and its A1 mirror: plays a granted blink
// pattern N times, then a one-step gap and a done pulse.
// Optional idle heartbeat enabled by defining LED_IDLE_HEARTBEAT_EN.
module led_pattern_arbiter
   import led_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int PAT_W    = LED_PAT_W,
   parameter int REP_W    = LED_REP_W,
   parameter int STEP_DIV = LED_STEP_DIV_DEFAULT
) (
   input  logic                 CLK,
   input  logic                 RST,
   led_pattern_arbiter_if.slave bus,
   output logic                 LED,
   output logic                 A1
);
   localparam int GID_W = $clog2(NUM_REQ);
   localparam int PS_W  = $clog2(STEP_DIV);
   localparam int BI_W  = $clog2(PAT_W);

   localparam logic [PS_W-1:0]    PS_LAST  = PS_W'(STEP_DIV - 1);
   localparam logic [PS_W-1:0]    PS_ONE   = PS_W'(1'b1);
   localparam logic [BI_W-1:0]    BI_LAST  = BI_W'(PAT_W - 1);
   localparam logic [BI_W-1:0]    BI_ONE   = BI_W'(1'b1);
   localparam logic [REP_W-1:0]   REP_ONE  = REP_W'(1'b1);
   localparam logic [GID_W-1:0]   GID_LAST = GID_W'(NUM_REQ - 1);
   localparam logic [NUM_REQ-1:0] ONE_REQ  = NUM_REQ'(1'b1);

   led_state_t         state_r, state_n;
   logic [PS_W-1:0]    ps_r, ps_n;
   logic [BI_W-1:0]    bi_r, bi_n;
   logic [REP_W-1:0]   rep_r, rep_n;
   logic [PAT_W-1:0]   pat_r, pat_n;
   logic [GID_W-1:0]   gid_r, gid_n;
   logic [GID_W-1:0]   last_r, last_n;
   logic [NUM_REQ-1:0] ready_r, ready_n;
   logic [NUM_REQ-1:0] done_r, done_n;
   logic               busy_r, busy_n;
   logic               led_r, a1_r, led_n;
   logic               any_s, hb_s, tick_s;
   logic [GID_W-1:0]   win_s;
   logic [PAT_W-1:0]   pat_slot_s [NUM_REQ];
   logic [REP_W-1:0]   rep_slot_s [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
      assign pat_slot_s[i] = bus.req_pattern[i*PAT_W +: PAT_W];
      assign rep_slot_s[i] = bus.req_repeat[i*REP_W +: REP_W];
   end

   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .req    (bus.req_valid),
      .last   (last_r),
      .any    (any_s),
      .gnt_id (win_s)
   );

`ifdef LED_IDLE_HEARTBEAT_EN
   logic [LED_HB_W-1:0] hb_cnt_r;

   // Free-running heartbeat timebase.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         hb_cnt_r <= {LED_HB_W{1'b0}};
      end else begin
         hb_cnt_r <= hb_cnt_r + LED_HB_W'(1'b1);
      end
   end

   assign hb_s = led_hb_on(hb_cnt_r);
`else
   assign hb_s = 1'b0;
`endif

   assign tick_s = (ps_r == PS_LAST);

   // Next-state and next-output decode for the arbitration/playback FSM.
   always_comb begin
      state_n = state_r;
      ps_n    = ps_r;
      bi_n    = bi_r;
      rep_n   = rep_r;
      pat_n   = pat_r;
      gid_n   = gid_r;
      last_n  = last_r;
      ready_n = {NUM_REQ{1'b0}};
      done_n  = {NUM_REQ{1'b0}};
      led_n   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            led_n = hb_s;
            if (any_s) begin
               state_n = ST_LOAD;
               gid_n   = win_s;
            end else begin
               state_n = ST_IDLE;
            end
         end
         ST_LOAD: begin
            // A requester that gave up before its ready pulse is simply dropped.
            if (bus.req_valid[gid_r]) begin
               ready_n = ONE_REQ << gid_r;
               pat_n   = pat_slot_s[gid_r];
               rep_n   = rep_slot_s[gid_r];
               last_n  = gid_r;
               ps_n    = {PS_W{1'b0}};
               bi_n    = {BI_W{1'b0}};
               led_n   = pat_slot_s[gid_r][0];
               state_n = ST_PLAY;
            end else begin
               state_n = ST_IDLE;
            end
         end
         ST_PLAY: begin
            if (tick_s) begin
               ps_n = {PS_W{1'b0}};
               if (bi_r == BI_LAST) begin
                  bi_n = {BI_W{1'b0}};
                  if (rep_r > REP_ONE) begin
                     rep_n = rep_r - REP_ONE;
                     led_n = pat_r[0];
                  end else if (rep_r == REP_ONE) begin
                     state_n = ST_GAP;
                  end else if (bus.req_valid[gid_r]) begin
                     led_n = pat_r[0];
                  end else begin
                     state_n = ST_GAP;
                  end
               end else begin
                  bi_n  = bi_r + BI_ONE;
                  led_n = pat_r[bi_n];
               end
            end else begin
               ps_n  = ps_r + PS_ONE;
               led_n = pat_r[bi_r];
            end
         end
         ST_GAP: begin
            if (tick_s) begin
               ps_n    = {PS_W{1'b0}};
               done_n  = ONE_REQ << gid_r;
               state_n = ST_IDLE;
            end else begin
               ps_n = ps_r + PS_ONE;
            end
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
      busy_n = (state_n != ST_IDLE);
   end

   // State and registered-output update; async reset aborts any playback silently.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_r <= ST_IDLE;
         ps_r    <= {PS_W{1'b0}};
         bi_r    <= {BI_W{1'b0}};
         rep_r   <= {REP_W{1'b0}};
         pat_r   <= {PAT_W{1'b0}};
         gid_r   <= {GID_W{1'b0}};
         last_r  <= GID_LAST;
         ready_r <= {NUM_REQ{1'b0}};
         done_r  <= {NUM_REQ{1'b0}};
         busy_r  <= 1'b0;
         led_r   <= 1'b0;
         a1_r    <= 1'b0;
      end else begin
         state_r <= state_n;
         ps_r    <= ps_n;
         bi_r    <= bi_n;
         rep_r   <= rep_n;
         pat_r   <= pat_n;
         gid_r   <= gid_n;
         last_r  <= last_n;
         ready_r <= ready_n;
         done_r  <= done_n;
         busy_r  <= busy_n;
         led_r   <= led_n;
         a1_r    <= led_n;
      end
   end

   assign bus.req_ready = ready_r;
   assign bus.done      = done_r;
   assign bus.busy      = busy_r;
   assign bus.grant_id  = gid_r;
   assign LED           = led_r;
   assign A1            = a1_r;

endmodule

// File: tb/tb_led_pattern_arbiter.sv
// Scoreboard bench for led_pattern_arbiter: stimulus predicts grants and LED
// traces into a queue, a negedge monitor checks what the DUT presents.
module tb_led_pattern_arbiter;
   localparam int NR = 4;
   localparam int PW = 8;
   localparam int RW = 4;
   localparam int SD = 4;

   logic CLK = 1'b0;
   logic RST;
   logic LED, A1;

   always #5 CLK = ~CLK;

   led_pattern_arbiter_if #(.NUM_REQ(NR), .PAT_W(PW), .REP_W(RW)) bus ();

   led_pattern_arbiter #(.NUM_REQ(NR), .PAT_W(PW), .REP_W(RW), .STEP_DIV(SD)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus),
      .LED (LED),
      .A1  (A1)
   );

   typedef struct {
      int            id;
      logic [PW-1:0] pat;
      int            plays;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   m_last = NR - 1;

   task automatic check(input bit ok, input string name, input longint act, input longint want);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
      end
   endtask

   function automatic int rr_pick(input logic [NR-1:0] pend, input int last);
      for (int k = 1; k <= NR; k++) begin
         int c;
         c = (last + k) % NR;
         if (((pend >> c) & NR'(1)) != '0) return c;
      end
      return -1;
   endfunction

   // LED seen k cycles after the ready pulse: each bit SD cycles, bit 0 first, then a gap.
   function automatic logic exp_led(input logic [PW-1:0] pat, input int plays, input int k);
      logic [PW-1:0] s;
      if (k < plays * PW * SD) begin
         s = pat >> ((k / SD) % PW);
         return s[0];
      end
      return 1'b0;
   endfunction

   // ---------------- monitor ----------------
   logic cap_trace[$];
   bit   capturing = 1'b0;
   exp_t mon_e;

   always @(negedge CLK) begin
      if (RST) begin
         capturing = 1'b0;
         exp_q.delete();
      end else begin
         check(A1 === LED, "a1_mirror", A1, LED);
         if (bus.req_ready != '0) begin
            check($onehot(bus.req_ready), "ready_onehot", bus.req_ready, 0);
            if (exp_q.size() == 0) begin
               check(1'b0, "unexpected_ready", bus.req_ready, 0);
            end else begin
               check(bus.req_ready == (NR'(1) << exp_q[0].id), "ready_id", bus.req_ready, NR'(1) << exp_q[0].id);
               check(bus.grant_id == exp_q[0].id, "grant_id", bus.grant_id, exp_q[0].id);
               capturing = 1'b1;
               cap_trace.delete();
               cap_trace.push_back(LED);
            end
         end else if (bus.done != '0) begin
            if (!capturing) begin
               check(1'b0, "unexpected_done", bus.done, 0);
            end else begin
               int n;
               int mis;
               mon_e = exp_q.pop_front();
               check(bus.done == (NR'(1) << mon_e.id), "done_id", bus.done, NR'(1) << mon_e.id);
               check(bus.busy == 1'b0, "busy_at_done", bus.busy, 0);
               n   = mon_e.plays * PW * SD + SD;
               mis = -1;
               for (int k = 0; k < cap_trace.size() && k < n; k++) begin
                  if (mis < 0 && cap_trace[k] !== exp_led(mon_e.pat, mon_e.plays, k)) mis = k;
               end
               check(cap_trace.size() == n, $sformatf("led_trace_len_id%0d", mon_e.id), cap_trace.size(), n);
               check(mis < 0, $sformatf("led_trace_bits_id%0d_first_bad_cycle", mon_e.id), mis, -1);
               capturing = 1'b0;
            end
         end else if (capturing) begin
            check(bus.busy == 1'b1, "busy_while_playing", bus.busy, 1);
            cap_trace.push_back(LED);
         end else begin
`ifndef LED_IDLE_HEARTBEAT_EN
            check(LED == 1'b0, "led_idle_zero", LED, 0);
`endif
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive_slot(input int i, input logic [PW-1:0] p, input int r);
      bus.req_pattern[i*PW +: PW] = p;
      bus.req_repeat[i*RW +: RW]  = RW'(r);
   endtask

   task automatic push_exp(input int id, input logic [PW-1:0] p, input int plays);
      exp_t e;
      e.id    = id;
      e.pat   = p;
      e.plays = plays;
      exp_q.push_back(e);
   endtask

   task automatic run_round(input logic [NR-1:0] set, input int rearm_id, input int rep_fixed,
                            input bit pat_fix, input logic [PW-1:0] pat_fixed);
      logic [PW-1:0] p[NR];
      int            r[NR];
      logic [PW-1:0] p2;
      int            r2;
      logic [NR-1:0] pend;
      int            pick, n_exp, n_done, cyc;
      bit            rearmed, rearm_done, first_ready;
      n_exp = 0; n_done = 0; cyc = 0;
      rearmed = 1'b0; rearm_done = 1'b0; first_ready = 1'b0;
      p2 = PW'($urandom);
      r2 = $urandom_range(2, 1);
      @(negedge CLK);
      for (int i = 0; i < NR; i++) begin
         p[i] = pat_fix ? pat_fixed : PW'($urandom);
         r[i] = (rep_fixed > 0) ? rep_fixed : $urandom_range(2, 1);
         drive_slot(i, p[i], r[i]);
      end
      // Reference: serve pending requesters in rotating order starting after the last winner.
      pend = set;
      while (pend != '0) begin
         pick = rr_pick(pend, m_last);
         push_exp(pick, p[pick], r[pick]);
         n_exp++;
         m_last = pick;
         pend = pend & ~(NR'(1) << pick);
         if (pick == rearm_id && !rearmed) begin
            pend    = pend | (NR'(1) << pick);
            p[pick] = p2;
            r[pick] = r2;
            rearmed = 1'b1;
         end
      end
      bus.req_valid = set;
      while (n_done < n_exp && cyc < 2000) begin
         @(negedge CLK);
         cyc++;
         if (bus.req_ready != '0 && !first_ready) begin
            first_ready = 1'b1;
            check(cyc == 2, "ready_latency", cyc, 2);
         end
         for (int i = 0; i < NR; i++) begin
            if (((bus.req_ready >> i) & NR'(1)) != '0) begin
               bus.req_valid = bus.req_valid & ~(NR'(1) << i);
               if (i == rearm_id && !rearm_done) begin
                  drive_slot(i, p2, r2);
                  bus.req_valid = bus.req_valid | (NR'(1) << i);
                  rearm_done = 1'b1;
               end
            end
         end
         if (bus.done != '0) n_done++;
      end
      check(n_done == n_exp, "round_complete", n_done, n_exp);
      repeat (3) @(negedge CLK);
   endtask

   task automatic run_cont(input int id, input int drop_c);
      logic [PW-1:0] p;
      int            cyc, c;
      bit            got_done;
      cyc = 0; c = -1; got_done = 1'b0;
      p = PW'($urandom);
      @(negedge CLK);
      drive_slot(id, p, 0);
      push_exp(id, p, drop_c / (PW * SD) + 1);
      m_last = id;
      bus.req_valid = NR'(1) << id;
      while (!got_done && cyc < 3000) begin
         @(negedge CLK);
         cyc++;
         if (c >= 0) c++;
         if (((bus.req_ready >> id) & NR'(1)) != '0) c = 0;
         if (c == drop_c) bus.req_valid = '0;
         if (bus.done != '0) got_done = 1'b1;
      end
      check(got_done, "cont_done_seen", got_done, 1);
      bus.req_valid = '0;
      repeat (3) @(negedge CLK);
   endtask

   initial begin
      int idle_bad, seen, cyc;
      RST = 1'b1;
      bus.req_valid   = '0;
      bus.req_pattern = '0;
      bus.req_repeat  = '0;
      #12;
      check(LED == 1'b0 && A1 == 1'b0, "reset_led", {LED, A1}, 0);
      check(bus.busy == 1'b0, "reset_busy", bus.busy, 0);
      check(bus.req_ready == '0 && bus.done == '0, "reset_ready_done", {bus.req_ready, bus.done}, 0);
      check(bus.grant_id == '0, "reset_grant_id", bus.grant_id, 0);
      @(negedge CLK);
      RST = 1'b0;

      idle_bad = 0;
      repeat (100) begin
         @(negedge CLK);
         if (LED !== 1'b0 || A1 !== 1'b0 || bus.busy !== 1'b0) idle_bad++;
      end
      check(idle_bad == 0, "idle_100_cycles", idle_bad, 0);

      // 8'hA5 twice: 1,0,1,0,0,1,0,1 per pass.
      run_round(4'b0001, -1, 2, 1'b1, 8'hA5);
      // Requesters 1 and 3 together, 1 re-asserts at its ready: order 1,3,1.
      run_round(4'b1010, 1, 1, 1'b0, 8'h00);
      // Continuous playback, valid dropped during the third pass.
      run_cont(2, $urandom_range(95, 64));
      run_cont(1, $urandom_range(40, 1));

      repeat (4) begin
         run_round(NR'($urandom_range(15, 1)), $urandom_range(3, 0), 0, 1'b0, 8'h00);
      end

      // Valid withdrawn during LOAD: no ready, back to idle.
      @(negedge CLK);
      drive_slot(3, 8'hFF, 1);
      bus.req_valid = 4'b1000;
      @(negedge CLK);
      bus.req_valid = '0;
      seen = 0;
      repeat (8) begin
         @(negedge CLK);
         if (bus.req_ready != '0) seen++;
      end
      check(seen == 0, "cancel_no_ready", seen, 0);
      check(bus.busy == 1'b0 && LED == 1'b0, "cancel_idle", {bus.busy, LED}, 0);

      // Asynchronous reset in the middle of playback.
      @(negedge CLK);
      drive_slot(2, 8'hFF, 2);
      push_exp(2, 8'hFF, 2);
      bus.req_valid = 4'b0100;
      cyc = 0;
      while (bus.req_ready == '0 && cyc < 20) begin
         @(negedge CLK);
         cyc++;
      end
      check(bus.req_ready == 4'b0100, "reset_test_grant", bus.req_ready, 4);
      bus.req_valid = '0;
      repeat (10) @(negedge CLK);
      @(posedge CLK);
      #2;
      RST = 1'b1;
      #1;
      check(LED == 1'b0 && A1 == 1'b0, "async_reset_led", {LED, A1}, 0);
      check(bus.busy == 1'b0, "async_reset_busy", bus.busy, 0);
      check(bus.grant_id == '0, "async_reset_grant_id", bus.grant_id, 0);
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      m_last = NR - 1;
      run_round(4'b0101, -1, 1, 1'b0, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
